// File: rtl/alu_pipe_mc.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe_mc
// Description : Sequential ALU with a valid/ready handshake on both sides.
//               Single-cycle ops (ADD/SUB/AND/OR/SLT/NOT/NOR) complete on
//               the accept edge; MUL iterates shift-add for WIDTH cycles.
//               The result is held until the consumer takes it; illegal
//               opcodes return zero with the err flag set.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe_mc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             err
);

    // Opcode encodings
    localparam logic [3:0] c_OP_ADD = 4'd1;
    localparam logic [3:0] c_OP_SUB = 4'd3;
    localparam logic [3:0] c_OP_AND = 4'd4;
    localparam logic [3:0] c_OP_MUL = 4'd6;
    localparam logic [3:0] c_OP_OR  = 4'd8;
    localparam logic [3:0] c_OP_SLT = 4'd10;
    localparam logic [3:0] c_OP_NOT = 4'd13;
    localparam logic [3:0] c_OP_NOR = 4'd15;

    localparam logic [CNT_W-1:0] c_MUL_ITERS = CNT_W'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic                   r_out_valid;
    logic [WIDTH-1:0]       r_result;
    logic                   r_carry;
    logic                   r_err;
    logic [2*WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]       r_mplier;
    logic [2*WIDTH-1:0]     r_acc;
    logic [CNT_W-1:0]       r_cnt;

    logic                   w_accept;
    logic [WIDTH:0]         w_add;
    logic [WIDTH:0]         w_sub;
    logic [WIDTH-1:0]       w_res;
    logic                   w_carry;
    logic                   w_err;
    logic [2*WIDTH-1:0]     w_acc_next;

    // A new op can enter when idle, or when the held result leaves this same edge
    assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign carry_out = r_carry;
    assign err       = r_err;

    // Carry is bit WIDTH of the extended sum; for SUB it is the no-borrow flag
    assign w_add = {1'b0, a} + {1'b0, b};
    assign w_sub = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    // One shift-add step: add the shifted multiplicand when the current multiplier bit is set
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // Single-cycle result decode; MUL is handled by the iterative path
    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_err   = 1'b0;
        case (op)
            c_OP_ADD: begin
                w_res   = w_add[WIDTH-1:0];
                w_carry = w_add[WIDTH];
            end
            c_OP_SUB: begin
                w_res   = w_sub[WIDTH-1:0];
                w_carry = w_sub[WIDTH];
            end
            c_OP_AND: w_res = a & b;
            c_OP_OR:  w_res = a | b;
            c_OP_SLT: w_res = {{(WIDTH-1){1'b0}}, (a < b)};
            c_OP_NOT: w_res = ~a;
            c_OP_NOR: w_res = ~(a | b);
            c_OP_MUL: w_res = '0;
            default:  w_err = 1'b1;
        endcase
    end

    // Control FSM and datapath registers; accepting has priority so DONE can chain back-to-back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_carry     <= 1'b0;
            r_err       <= 1'b0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
        end else if (w_accept) begin
            if (op == c_OP_MUL) begin
                r_mcand     <= {{WIDTH{1'b0}}, a};
                r_mplier    <= b;
                r_acc       <= '0;
                r_cnt       <= '0;
                r_out_valid <= 1'b0;
                r_state     <= S_MUL;
            end else begin
                r_result    <= w_res;
                r_carry     <= w_carry;
                r_err       <= w_err;
                r_out_valid <= 1'b1;
                r_state     <= S_DONE;
            end
        end else begin
            case (r_state)
                S_MUL: begin
                    if (r_cnt == c_MUL_ITERS) begin
                        // All partial products summed: publish the low half, flag overflow from the high half
                        r_result    <= r_acc[WIDTH-1:0];
                        r_carry     <= |r_acc[2*WIDTH-1:WIDTH];
                        r_err       <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_acc    <= w_acc_next;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
